// File: rtl/spi_rx.sv
// SPI mode-3 receiver for the 8-bit display link.
// Deserializes {dc, byte} words into a show-ahead FIFO read by the CPU.
module spi_rx #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          reset_,
   input  logic          cs_,
   input  logic          sck,
   input  logic          sdi,
   input  logic          dc,
   input  logic          rd,
   input  logic          clr,
   output logic [8:0]    rdata,
   output logic          valid,
   output logic [AW:0]   count,
   output logic          ovf,
   output logic          ferr
);

   localparam int unsigned WW = 9;

   typedef enum logic {IDLE, SHIFT} state_t;

   logic [1:0] cs_sync, sck_sync, sdi_sync, dc_sync;
   logic       cs_s, sck_s, sdi_s, dc_s, sck_prev, sck_rise;

   state_t     state, state_nxt;
   logic [2:0] bitcnt, bitcnt_nxt;
   logic [7:0] shreg, shreg_nxt;
   logic       push, frame_err;
   logic [WW-1:0] wdata;

   logic [WW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   cnt;
   logic          full, pop, do_push, ovf_set;

   // 2-FF synchronizers; cs_ and sck reset to their idle-high level
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         cs_sync  <= 2'b11;
         sck_sync <= 2'b11;
         sdi_sync <= 2'b00;
         dc_sync  <= 2'b00;
         sck_prev <= 1'b1;
      end else begin
         cs_sync  <= {cs_sync[0], cs_};
         sck_sync <= {sck_sync[0], sck};
         sdi_sync <= {sdi_sync[0], sdi};
         dc_sync  <= {dc_sync[0], dc};
         sck_prev <= sck_s;
      end
   end

   assign cs_s     = cs_sync[1];
   assign sck_s    = sck_sync[1];
   assign sdi_s    = sdi_sync[1];
   assign dc_s     = dc_sync[1];
   assign sck_rise = sck_s & ~sck_prev;
   assign wdata    = {dc_s, shreg[6:0], sdi_s};

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state  <= IDLE;
         bitcnt <= 3'd0;
         shreg  <= 8'd0;
      end else begin
         state  <= state_nxt;
         bitcnt <= bitcnt_nxt;
         shreg  <= shreg_nxt;
      end
   end

   // A byte completing on the same clk that cs_ rises is kept, not flagged
   always_comb begin
      state_nxt  = state;
      bitcnt_nxt = bitcnt;
      shreg_nxt  = shreg;
      push       = 1'b0;
      frame_err  = 1'b0;
      case (state)
         IDLE: begin
            bitcnt_nxt = 3'd0;
            if (!cs_s) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (sck_rise) begin
               shreg_nxt  = {shreg[6:0], sdi_s};
               bitcnt_nxt = bitcnt + 3'd1;
               push       = (bitcnt == 3'd7);
            end
            if (cs_s) begin
               state_nxt  = IDLE;
               frame_err  = (bitcnt_nxt != 3'd0);
               bitcnt_nxt = 3'd0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign valid   = (cnt != '0);
   assign pop     = rd & valid;
   assign do_push = push & (~full | pop);
   assign ovf_set = push & full & ~pop;

   // FIFO storage, pointers and sticky flags; clr wins over push and flag set
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
         ovf  <= 1'b0;
         ferr <= 1'b0;
      end else if (clr) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
         ovf  <= 1'b0;
         ferr <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + AW'(1);
         end
         if (pop) rptr <= rptr + AW'(1);
         case ({do_push, pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
         if (ovf_set)   ovf  <= 1'b1;
         if (frame_err) ferr <= 1'b1;
      end
   end

   assign rdata = valid ? mem[rptr] : '0;
   assign count = cnt;

endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx: latency, multi-byte frames, framing error,
// overflow, full push+pop, and mid-frame reset.
module tb_spi_rx;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int PH = 6;

   logic          clk = 1'b0;
   logic          reset_, cs_, sck, sdi, dc, rd, clr;
   logic [8:0]    rdata;
   logic          valid, ovf, ferr;
   logic [AW:0]   count;

   int n_cmp = 0;
   int n_err = 0;

   spi_rx #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset_(reset_), .cs_(cs_), .sck(sck), .sdi(sdi), .dc(dc),
      .rd(rd), .clr(clr), .rdata(rdata), .valid(valid), .count(count),
      .ovf(ovf), .ferr(ferr)
   );

   always #8 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic begin_frame(input logic dcv);
      @(negedge clk);
      dc  = dcv;
      cs_ = 1'b0;
   endtask

   // Returns on the clk negedge where the last sampled sck rise is driven
   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         repeat (PH) @(negedge clk);
         sck = 1'b0;
         sdi = b[7-i];
         repeat (PH) @(negedge clk);
         sck = 1'b1;
      end
   endtask

   task automatic end_frame();
      repeat (PH) @(negedge clk);
      cs_ = 1'b1;
      repeat (PH) @(negedge clk);
   endtask

   task automatic pop();
      @(negedge clk);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      #1;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      #1;
   endtask

   initial begin
      reset_ = 1'b0; cs_ = 1'b1; sck = 1'b1; sdi = 1'b0; dc = 1'b0;
      rd = 1'b0; clr = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_rdata", 16'(rdata), 16'h000);
      chk("rst_valid", 16'(valid), 16'h0);
      chk("rst_count", 16'(count), 16'h0);
      chk("rst_flags", 16'({ovf, ferr}), 16'h0);
      @(negedge clk);
      reset_ = 1'b1;
      repeat (2) @(negedge clk);

      // 1: latency of a single word
      begin_frame(1'b1);
      send_bits(8'hA5, 8);
      repeat (2) @(posedge clk);
      #1;
      chk("t1_valid_edge2", 16'(valid), 16'h0);
      @(posedge clk);
      #1;
      chk("t1_valid_edge3", 16'(valid), 16'h1);
      chk("t1_rdata", 16'(rdata), 16'h1A5);
      chk("t1_count", 16'(count), 16'h1);
      end_frame();
      pop();
      chk("t1_valid_pop", 16'(valid), 16'h0);
      chk("t1_rdata_pop", 16'(rdata), 16'h000);

      // 2: three back-to-back command bytes
      begin_frame(1'b0);
      send_bits(8'h3C, 8);
      send_bits(8'h00, 8);
      send_bits(8'hFF, 8);
      end_frame();
      chk("t2_count", 16'(count), 16'h3);
      chk("t2_ferr", 16'(ferr), 16'h0);
      chk("t2_w0", 16'(rdata), 16'h03C);
      pop();
      chk("t2_w1", 16'(rdata), 16'h000);
      pop();
      chk("t2_w2", 16'(rdata), 16'h0FF);
      pop();
      chk("t2_empty", 16'(valid), 16'h0);

      // 3: aborted frame then a good byte
      begin_frame(1'b1);
      send_bits(8'hF0, 5);
      end_frame();
      chk("t3_ferr_abort", 16'(ferr), 16'h1);
      chk("t3_count_abort", 16'(count), 16'h0);
      begin_frame(1'b1);
      send_bits(8'h81, 8);
      end_frame();
      chk("t3_ferr", 16'(ferr), 16'h1);
      chk("t3_count", 16'(count), 16'h1);
      chk("t3_rdata", 16'(rdata), 16'h181);
      pulse_clr();
      chk("t3_ferr_clr", 16'(ferr), 16'h0);
      chk("t3_count_clr", 16'(count), 16'h0);

      // 4: overflow
      begin_frame(1'b0);
      for (int i = 0; i <= 16; i++) send_bits(8'(i), 8);
      end_frame();
      chk("t4_count", 16'(count), 16'd16);
      chk("t4_ovf", 16'(ovf), 16'h1);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t4_rd%0d", i), 16'(rdata), 16'(i));
         pop();
      end
      chk("t4_empty", 16'(valid), 16'h0);
      pulse_clr();
      chk("t4_ovf_clr", 16'(ovf), 16'h0);

      // 5: push and pop on the same clk while full, then rd while empty
      begin_frame(1'b0);
      for (int i = 0; i < 16; i++) send_bits(8'(8'h20 + i), 8);
      repeat (PH) @(negedge clk);
      chk("t5_full", 16'(count), 16'd16);
      send_bits(8'h30, 8);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      #1;
      chk("t5_count", 16'(count), 16'd16);
      chk("t5_ovf", 16'(ovf), 16'h0);
      chk("t5_head", 16'(rdata), 16'h021);
      end_frame();
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t5_rd%0d", i), 16'(rdata), 16'(9'h021 + 9'(i)));
         pop();
      end
      pop();
      chk("t5_rd_empty_count", 16'(count), 16'h0);
      chk("t5_rd_empty_valid", 16'(valid), 16'h0);
      chk("t5_rd_empty_rdata", 16'(rdata), 16'h000);

      // 6: reset mid-byte with words queued
      begin_frame(1'b1);
      send_bits(8'h11, 8);
      send_bits(8'h22, 8);
      send_bits(8'h33, 8);
      send_bits(8'h44, 4);
      repeat (PH) @(negedge clk);
      chk("t6_pre_count", 16'(count), 16'h3);
      reset_ = 1'b0;
      #1;
      chk("t6_rst_rdata", 16'(rdata), 16'h000);
      chk("t6_rst_valid", 16'(valid), 16'h0);
      chk("t6_rst_count", 16'(count), 16'h0);
      chk("t6_rst_flags", 16'({ovf, ferr}), 16'h0);
      @(negedge clk);
      cs_ = 1'b1;
      sck = 1'b1;
      @(negedge clk);
      reset_ = 1'b1;
      repeat (2) @(negedge clk);
      begin_frame(1'b1);
      send_bits(8'h55, 8);
      end_frame();
      chk("t6_rdata", 16'(rdata), 16'h155);
      chk("t6_count", 16'(count), 16'h1);
      chk("t6_ferr", 16'(ferr), 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spi_rx.md
Name: spi_rx

Overview:
- SPI receive end of the 8-bit display link, and the counterpart of the SPI output driver.
- Samples an incoming cs_/sck/sdi/dc stream (mode 3: sck idles high, data changes on falling edge, sampled on rising edge, MSB first).
- Deserializes each byte with its D/C flag into a small show-ahead FIFO that the CPU drains through a memory-mapped read port.
- Used as an on-board loopback/monitor for the display link and as a receiver for external SPI masters.

Parameters:
DEPTH, 16, FIFO depth in words; power of two, minimum 2.
AW, 4, log2(DEPTH); width of the FIFO pointers.

Ports:
clk  input  1  system clock, 62.5MHz.
reset_  input  1  asynchronous active-low reset.
cs_  input  1  chip select, active low, asynchronous to clk.
sck  input  1  serial clock, asynchronous to clk, idles high.
sdi  input  1  serial data in.
dc  input  1  data/command flag, 1=data, 0=command; stable while cs_ is low.
rd  input  1  pop strobe, one clk per word.
clr  input  1  clears the sticky error flags and empties the FIFO.
rdata  output  9  FIFO head {dc, byte[7:0]}.
valid  output  1  FIFO not empty.
count  output  AW+1  words held, 0..DEPTH.
ovf  output  1  sticky flag: a word was dropped because the FIFO was full.
ferr  output  1  sticky flag: cs_ rose mid-byte.

Behaviour:
Reset:
- Applied asynchronously on reset_ low; all internal state cleared.
- Output reset values: rdata=0, valid=0, count=0, ovf=0, ferr=0.
- Reset mid-frame drops the partial byte and all queued words.

Input synchronization:
- cs_, sck, sdi, dc each pass through a 2-FF synchronizer; synchronizer reset values are cs_=1, sck=1, others 0.
- Rising-edge detect on synced sck = sck_s & ~sck_prev.
- sck high and low phases must each be at least 4 clk periods. The link runs at 1.25MHz, about 25 clk per phase.

Receiver state machine (states IDLE, SHIFT):
- IDLE: synced cs_ high; bitcnt=0; sck edges ignored. Synced cs_ low -> SHIFT.
- SHIFT, on each sck rising edge: shreg <= {shreg[6:0], sdi_s}; bitcnt <= bitcnt+1.
- SHIFT, when the sampled edge is the 8th (bitcnt==7): push {dc_s, shreg[6:0], sdi_s} on that same clk edge; bitcnt wraps to 0.
- Back-to-back bytes under one cs_ low are supported.
- SHIFT, synced cs_ high: -> IDLE. If bitcnt!=0, the partial byte is discarded and ferr<=1. If bitcnt==0, no error.
- If cs_ rises on the same clk as an 8th-bit edge, the byte is pushed and ferr is not set.

Latency:
- Counting the 8th sck rising edge at the pin as arriving before clk edge 1, the word is written at clk edge 3.
- valid and rdata reflect the word after edge 3.

FIFO:
- Registered array with AW-bit read/write pointers wrapping modulo DEPTH.
- rdata is combinational from the head entry (show-ahead).
- rdata = 0 when empty.
- Pop: rd & valid advances the read pointer. rd while empty is ignored and changes nothing.
- Push while full with no simultaneous pop: word dropped, ovf<=1, pointers unchanged.
- Push and pop in the same cycle: both occur, count unchanged. This holds when full (no ovf) and when count==1. When empty, only the push occurs.
- count increments on push-only and decrements on pop-only.
- clr: pointers and count <= 0, ovf <= 0, ferr <= 0. clr has priority over a push or set in the same cycle. The shift register and bitcnt are not affected.

Test Plan:
1. After reset, one frame dc=1, byte 0xA5 -> exactly 3 clk after the 8th sck rise, valid=1, rdata=0x1A5, count=1. One rd -> valid=0, rdata=0.
2. One cs_ low frame carrying 0x3C,0x00,0xFF with dc=0 -> rdata pops 0x03C, 0x000, 0x0FF in order; ferr=0.
3. Frame aborted after 5 bits, then a full byte 0x81 with dc=1 -> ferr=1, only 0x181 is queued, count=1. Pulse clr -> ferr=0, count=0.
4. Send 17 bytes 0x00..0x10 with no reads (DEPTH=16) -> count=16, ovf=1. Reads return 0x000..0x00F; 0x010 is lost.
5. With the FIFO full, pulse rd on the clk of a push -> count stays 16, ovf stays 0, new word at the tail. With the FIFO empty, rd alone -> no change.
6. Assert reset_ low mid-byte with 3 words queued -> all outputs 0 at once. The next clean frame 0x55 with dc=1 gives rdata=0x155.
